window3_gen: RTL and testbench

//   Streaming 3-tap sliding-window generator for Q8.8 feature maps. Sits directly

---
 rtl/window3_gen.sv | 145 ++++++++++++++
 tb/tb_window3_gen.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/window3_gen.sv
// window3_gen: streaming 3-tap sliding-window generator for Q8.8 feature maps.
// Each channel's FRAME_LEN-sample stream becomes FRAME_LEN windows
// {x[i-1], x[i], x[i+1]}. Both edges are padded, and valid/ready flow control
// is used on the input and the output side.
// Optional feature macro: REFLECT_PAD_EN.
//   - Defined: the edges use reflection padding.
//   - Undefined: the edges use zero padding.
module window3_gen #(
    parameter int DATA_WIDTH = 16,
    parameter int CHANNELS   = 4,
    parameter int FRAME_LEN  = 16,
    localparam int CH_W      = (CHANNELS  > 1) ? $clog2(CHANNELS)  : 1,
    localparam int POS_W     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    valid_in,
    output logic                    ready_in,
    output logic [3*DATA_WIDTH-1:0] win_out,
    output logic                    valid_out,
    input  logic                    ready_out,
    output logic [CH_W-1:0]         ch_idx,
    output logic [POS_W-1:0]        pos_idx,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [2:0] {IDLE, FILL, RUN, FLUSH, DRAIN, DONE} state_t;

    localparam logic [POS_W-1:0] LAST_POS = POS_W'(FRAME_LEN - 1);
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(CHANNELS - 1);

    state_t                  state, next_state;
    logic [DATA_WIDTH-1:0]   s_prev, s_cur;
    logic [POS_W-1:0]        in_cnt;
    logic [CH_W-1:0]         ch_cnt;
    logic                    slot_free, accept;
    logic                    emit, ch_inc;
    logic [3*DATA_WIDTH-1:0] emit_win;
    logic [POS_W-1:0]        emit_pos;
    logic [DATA_WIDTH-1:0]   left_run, right_flush;

    assign slot_free = !valid_out || ready_out;
    assign accept    = valid_in && ready_in;
    assign busy      = (state == FILL) || (state == RUN) || (state == FLUSH) || (state == DRAIN);
    assign done      = (state == DONE);

    // Edge padding: reflection reuses in-channel neighbours, so no data crosses channels.
`ifdef REFLECT_PAD_EN
    assign left_run    = (in_cnt == POS_W'(1)) ? data_in : s_prev;
    assign right_flush = s_prev;
`else
    assign left_run    = s_prev;
    assign right_flush = '0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state, input handshake and emit decode.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        next_state = state;
        ready_in   = 1'b0;
        emit       = 1'b0;
        ch_inc     = 1'b0;
        emit_win   = '0;
        emit_pos   = '0;
        case (state)
            IDLE: if (start) next_state = FILL;
            FILL: begin
                ready_in = 1'b1;
                if (valid_in) next_state = RUN;
            end
            RUN: begin
                ready_in = slot_free;
                if (valid_in && slot_free) begin
                    emit     = 1'b1;
                    emit_win = {left_run, s_cur, data_in};
                    emit_pos = in_cnt - POS_W'(1);
                    if (in_cnt == LAST_POS) next_state = FLUSH;
                end
            end
            FLUSH: begin
                if (slot_free) begin
                    emit     = 1'b1;
                    emit_win = {s_prev, s_cur, right_flush};
                    emit_pos = LAST_POS;
                    if (ch_cnt == LAST_CH) begin
                        next_state = DRAIN;
                    end else begin
                        ch_inc     = 1'b1;
                        next_state = FILL;
                    end
                end
            end
            DRAIN: if (slot_free) next_state = DONE;
            DONE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Sample history, counters and the registered output window.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_prev    <= '0;
            s_cur     <= '0;
            in_cnt    <= '0;
            ch_cnt    <= '0;
            win_out   <= '0;
            ch_idx    <= '0;
            pos_idx   <= '0;
            valid_out <= 1'b0;
        end else begin
            if (state == IDLE && start) ch_cnt <= '0;
            if (ch_inc) ch_cnt <= ch_cnt + CH_W'(1);

            if (state == FILL && accept) begin
                s_prev <= '0;
                s_cur  <= data_in;
                in_cnt <= POS_W'(1);
            end else if (state == RUN && accept) begin
                s_prev <= s_cur;
                s_cur  <= data_in;
                in_cnt <= in_cnt + POS_W'(1);
            end

            if (emit) begin
                win_out   <= emit_win;
                ch_idx    <= ch_cnt;
                pos_idx   <= emit_pos;
                valid_out <= 1'b1;
            end else if (ready_out) begin
                valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_window3_gen.sv
// tb_window3_gen: a scoreboard test for window3_gen, built with CHANNELS=2 and FRAME_LEN=4.
// Expected windows come from the sample arrays by direct index arithmetic.
// The padding model follows REFLECT_PAD_EN in the same way as the design.
module tb_window3_gen;

    localparam int DW  = 16;
    localparam int CH  = 2;
    localparam int FL  = 4;
    localparam int CHW = 1;
    localparam int PW  = 2;
    localparam int EW  = 3*DW + CHW + PW;

    logic            clk = 1'b0;
    logic            rst, start, valid_in, ready_out;
    logic [DW-1:0]   data_in;
    logic            ready_in, valid_out, busy, done;
    logic [3*DW-1:0] win_out;
    logic [CHW-1:0]  ch_idx;
    logic [PW-1:0]   pos_idx;

    window3_gen #(.DATA_WIDTH(DW), .CHANNELS(CH), .FRAME_LEN(FL)) dut (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in), .valid_in(valid_in),
        .ready_in(ready_in), .win_out(win_out), .valid_out(valid_out), .ready_out(ready_out),
        .ch_idx(ch_idx), .pos_idx(pos_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int frames = 0;
    int bp_mode = 0;          // 0: ready_out high, 1: random, 2: driven by hand
    bit ignore_mon = 1'b0;

    logic [EW-1:0] sb_q[$];
    logic [DW-1:0] samp [CH*FL];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one window per position, computed from the sample array.
    task automatic push_expected();
        logic [DW-1:0] l, c, r;
        for (int ch = 0; ch < CH; ch++) begin
            for (int i = 0; i < FL; i++) begin
                c = samp[ch*FL + i];
`ifdef REFLECT_PAD_EN
                l = (i == 0)      ? samp[ch*FL + 1]      : samp[ch*FL + i - 1];
                r = (i == FL - 1) ? samp[ch*FL + FL - 2] : samp[ch*FL + i + 1];
`else
                l = (i == 0)      ? '0 : samp[ch*FL + i - 1];
                r = (i == FL - 1) ? '0 : samp[ch*FL + i + 1];
`endif
                sb_q.push_back({l, c, r, CHW'(ch), PW'(i)});
            end
        end
    endtask

    // Random ready_out, changed just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (bp_mode == 0)      ready_out = 1'b1;
        else if (bp_mode == 1) ready_out = 1'($urandom_range(0, 1));
    end

    // Monitor: pop and compare on each output handshake; check hold stability.
    logic          hold_pending = 1'b0;
    logic [EW-1:0] hold_val;
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (rst || ignore_mon) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                check("hold_valid", 64'(valid_out), 64'd1);
                check("hold_stable", 64'({win_out, ch_idx, pos_idx}), 64'(hold_val));
            end
            hold_pending = 1'b0;
            if (valid_out && ready_out) begin
                check("sb_nonempty", 64'(sb_q.size() > 0), 64'd1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check("window", 64'({win_out, ch_idx, pos_idx}), 64'(e));
                end
            end else if (valid_out) begin
                hold_pending = 1'b1;
                hold_val     = {win_out, ch_idx, pos_idx};
            end
            if (done) begin
                done_cnt++;
                check("done_queue_empty", 64'(sb_q.size()), 64'd0);
            end
        end
    end

    task automatic fill_random();
        for (int k = 0; k < CH*FL; k++) begin
            case ($urandom_range(0, 3))
                0:       samp[k] = 16'hFF00;
                1:       samp[k] = 16'h8000;
                default: samp[k] = 16'($urandom);
            endcase
        end
    endtask

    task automatic send(input logic [DW-1:0] d, input bit gaps);
        bit got = 1'b0;
        if (gaps) begin
            while ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
        end
        valid_in = 1'b1;
        data_in  = d;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (ready_in) begin
                got = 1'b1;
                break;
            end
        end
        check("accept_timeout", 64'(got), 64'd1);
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input bit start_in_done);
        bit got = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        check("done_timeout", 64'(got), 64'd1);
        if (start_in_done) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("done_count", 64'(done_cnt), 64'(frames));
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'd0);
        if (start_in_done) begin
            repeat (4) @(negedge clk);
            check("start_in_done_ignored", 64'(busy), 64'd0);
        end
    endtask

    task automatic run_frame(input bit gaps, input bit start_mid, input bit start_in_done);
        push_expected();
        frames++;
        pulse_start();
        for (int k = 0; k < CH*FL; k++) begin
            send(samp[k], gaps);
            if (start_mid && k == 2) pulse_start();
        end
        wait_done(start_in_done);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; valid_in = 1'b0; data_in = '0; ready_out = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state.
        @(negedge clk);
        check("rst_valid_out", 64'(valid_out), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_ready_in", 64'(ready_in), 64'd0);
        check("rst_win_out", 64'(win_out), 64'd0);
        check("rst_idx", 64'({ch_idx, pos_idx}), 64'd0);

        // Directed ramp: both channels carry 0x0100..0x0400.
        for (int k = 0; k < CH*FL; k++) samp[k] = 16'((k % FL + 1) * 256);
        run_frame(1'b0, 1'b0, 1'b0);

        // Hold {100,200,300} for three cycles with ready_out low.
        bp_mode = 2;
        ready_out = 1'b1;
        push_expected();
        frames++;
        pulse_start();
        for (int k = 0; k < CH*FL; k++) begin
            send(samp[k], 1'b0);
            if (k == 2) begin
                ready_out = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("stall_ready_in", 64'(ready_in), 64'd0);
                end
                @(posedge clk); #1;
                ready_out = 1'b1;
            end
        end
        wait_done(1'b0);

        // Random samples, including negative ones, with input gaps and output backpressure.
        bp_mode = 1;
        repeat (4) begin
            fill_random();
            run_frame(1'b1, 1'b0, 1'b0);
        end

        // A start pulse during RUN and another in the DONE cycle are both ignored.
        fill_random();
        run_frame(1'b1, 1'b1, 1'b1);

        // Abort mid-RUN after two windows, then replay the same frame.
        bp_mode = 0;
        @(posedge clk); #1;
        ignore_mon = 1'b1;
        fill_random();
        pulse_start();
        for (int k = 0; k < 3; k++) send(samp[k], 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_valid_out", 64'(valid_out), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_done_count", 64'(done_cnt), 64'(frames));
        ignore_mon = 1'b0;
        run_frame(1'b0, 1'b0, 1'b0);

        // More random traffic with backpressure.
        bp_mode = 1;
        repeat (4) begin
            fill_random();
            run_frame(1'b1, 1'b0, 1'b0);
        end

        repeat (4) @(negedge clk);
        check("final_queue_empty", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
